// File: rtl/unified_mem.sv
// Single-bank word memory shared by the fetch (I) and load/store (D) ports, with a LATENCY-deep read pipeline.
// Optional write protection below PROT_LIMIT is enabled by defining MEM_PROTECT_EN (adds the d_err port).
module unified_mem #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4,
    parameter int PROT_LIMIT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata
`ifdef MEM_PROTECT_EN
    ,
    output logic                  d_err
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [ADDR_W:0] PROT_LIM_W = (ADDR_W + 1)'(PROT_LIMIT);
`ifdef MEM_PROTECT_EN
    localparam logic PROT_ON = 1'b1;
`else
    localparam logic PROT_ON = 1'b0;
`endif

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [3:0]        starve_cnt;

    logic              rd_go_p0;
    logic              tag_p0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic              wr_go;
    logic              wr_block;

    logic              feed_vld;
    logic              feed_tag;
    logic [DATA_W-1:0] feed_data;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt == STARVE_LIM) ? cnt : cnt + 4'd1;
    endfunction

    // Arbitration: D normally wins, I is forced through once it has lost STARVE_MAX times in a row.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && (!d_req || starve_cnt == STARVE_LIM))
                i_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (i_req && !i_gnt)
            starve_cnt <= sat_inc(starve_cnt);
        else
            starve_cnt <= '0;
    end

    // Stage p0: the single granted access hits the array at the grant edge.
    assign rd_go_p0 = i_gnt || (d_gnt && !d_we);
    assign tag_p0   = d_gnt;
    assign rd_addr  = i_gnt ? i_addr : d_addr;
    assign rd_word  = mem[rd_addr];
    assign wr_go    = d_gnt && d_we;
    assign wr_block = PROT_ON && ({1'b0, d_addr} < PROT_LIM_W);

`ifdef MEM_PROTECT_EN
    logic err_p0;
    logic feed_err;
    assign err_p0 = wr_go && wr_block;
`endif

    always_ff @(posedge clk) begin
        if (wr_go && !wr_block) begin
            for (int b = 0; b < BE_W; b++) begin
                if (d_be[b])
                    mem[d_addr][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    // Stages p1..p(LATENCY-1): delay line carrying valid, port tag and read data.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign feed_vld  = rd_go_p0;
            assign feed_tag  = tag_p0;
            assign feed_data = rd_word;
`ifdef MEM_PROTECT_EN
            assign feed_err  = err_p0;
`endif
        end else begin : g_pipe
            logic              vld_p  [LATENCY-1];
            logic              tag_p  [LATENCY-1];
            logic [DATA_W-1:0] data_p [LATENCY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < LATENCY - 1; s++) begin
                        vld_p[s] <= 1'b0;
                        tag_p[s] <= 1'b0;
                    end
                end else begin
                    vld_p[0] <= rd_go_p0;
                    tag_p[0] <= tag_p0;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        vld_p[s] <= vld_p[s-1];
                        tag_p[s] <= tag_p[s-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                data_p[0] <= rd_word;
                for (int s = 1; s < LATENCY - 1; s++)
                    data_p[s] <= data_p[s-1];
            end

            assign feed_vld  = vld_p[LATENCY-2];
            assign feed_tag  = tag_p[LATENCY-2];
            assign feed_data = data_p[LATENCY-2];

`ifdef MEM_PROTECT_EN
            logic err_p [LATENCY-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < LATENCY - 1; s++)
                        err_p[s] <= 1'b0;
                end else begin
                    err_p[0] <= err_p0;
                    for (int s = 1; s < LATENCY - 1; s++)
                        err_p[s] <= err_p[s-1];
                end
            end
            assign feed_err = err_p[LATENCY-2];
`endif
        end
    endgenerate

    // Final stage: per-port output registers; rdata only reloads on its own port's response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= feed_vld && !feed_tag;
            d_rvalid <= feed_vld && feed_tag;
            if (feed_vld && !feed_tag)
                i_rdata <= feed_data;
            if (feed_vld && feed_tag)
                d_rdata <= feed_data;
        end
    end

`ifdef MEM_PROTECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            d_err <= 1'b0;
        else
            d_err <= feed_err;
    end
`endif

endmodule

// File: tb/tb_unified_mem.sv
// Bench for unified_mem: two instances (LATENCY 1 and 3) share stimulus and are checked every cycle
// against a transaction-level model (word array + response list keyed by grant cycle).
`timescale 1ns/1ps
module tb_unified_mem;
    localparam int DW = 32, AW = 10, BW = DW / 8, SM = 4, PL = 256, DEPTH = 1 << AW;
`ifdef MEM_PROTECT_EN
    localparam bit PROT = 1'b1;
    localparam logic [AW-1:0] B2B = 10'h300;
`else
    localparam bit PROT = 1'b0;
    localparam logic [AW-1:0] B2B = 10'h000;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_wdata;
    logic ig [2], dg [2], iv [2], dv [2];
    logic [DW-1:0] ir [2], dr [2];
`ifdef MEM_PROTECT_EN
    logic de [2];
`endif

    unified_mem #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(1), .STARVE_MAX(SM), .PROT_LIMIT(PL)) u1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(ig[0]), .i_rvalid(iv[0]), .i_rdata(ir[0]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(dg[0]), .d_rvalid(dv[0]), .d_rdata(dr[0])
`ifdef MEM_PROTECT_EN
        , .d_err(de[0])
`endif
    );

    unified_mem #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(3), .STARVE_MAX(SM), .PROT_LIMIT(PL)) u3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(ig[1]), .i_rvalid(iv[1]), .i_rdata(ir[1]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(dg[1]), .d_rvalid(dv[1]), .d_rdata(dr[1])
`ifdef MEM_PROTECT_EN
        , .d_err(de[1])
`endif
    );

    typedef struct {
        int            gc;
        bit            port;
        bit            err;
        logic [DW-1:0] data;
        logic [DW-1:0] msk;
    } ent_t;

    ent_t q[$];
    int LAT [2] = '{1, 3};
    int cyc = 0;
    int starve = 0;
    bit i_taken = 1'b0, d_taken = 1'b0;
    logic [DW-1:0] mm [DEPTH];
    logic [BW-1:0] kn [DEPTH];
    logic [DW-1:0] hi [2], him [2], hd [2], hdm [2];
    int n_chk = 0, n_fail = 0;
    logic eiv, edv, eer, eig, edg;

    task automatic chk(input string nm, input int u, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp, input logic [DW-1:0] msk = '1);
        n_chk++;
        if (((act ^ exp) & msk) !== '0) begin
            n_fail++;
            $display("FAIL %s dut=L%0d cyc=%0d actual=%h required=%h", nm, LAT[u], cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bytemask(input logic [BW-1:0] k);
        logic [DW-1:0] m = '0;
        for (int b = 0; b < BW; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : model
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("rst_i_gnt", k, ig[k], 0);
                chk("rst_d_gnt", k, dg[k], 0);
                chk("rst_i_rvalid", k, iv[k], 0);
                chk("rst_d_rvalid", k, dv[k], 0);
                chk("rst_i_rdata", k, ir[k], 0);
                chk("rst_d_rdata", k, dr[k], 0);
`ifdef MEM_PROTECT_EN
                chk("rst_d_err", k, de[k], 0);
`endif
                hi[k] = '0; him[k] = '1; hd[k] = '0; hdm[k] = '1;
            end
            q.delete();
            starve = 0;
            i_taken = 1'b0;
            d_taken = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                eiv = 1'b0; edv = 1'b0; eer = 1'b0;
                foreach (q[j]) begin
                    if (q[j].gc + LAT[k] == cyc) begin
                        if (q[j].err) eer = 1'b1;
                        else if (q[j].port) begin edv = 1'b1; hd[k] = q[j].data; hdm[k] = q[j].msk; end
                        else begin eiv = 1'b1; hi[k] = q[j].data; him[k] = q[j].msk; end
                    end
                end
                chk("i_rvalid", k, iv[k], eiv);
                chk("d_rvalid", k, dv[k], edv);
                chk("i_rdata", k, ir[k], hi[k], him[k]);
                chk("d_rdata", k, dr[k], hd[k], hdm[k]);
`ifdef MEM_PROTECT_EN
                chk("d_err", k, de[k], eer);
`endif
            end
            while (q.size() > 0 && q[0].gc + 3 <= cyc) void'(q.pop_front());

            eig = i_req && (!d_req || starve == SM);
            edg = d_req && !eig;
            for (int k = 0; k < 2; k++) begin
                chk("i_gnt", k, ig[k], eig);
                chk("d_gnt", k, dg[k], edg);
            end
            if (eig)
                q.push_back('{gc: cyc, port: 1'b0, err: 1'b0, data: mm[i_addr], msk: bytemask(kn[i_addr])});
            if (edg) begin
                if (!d_we)
                    q.push_back('{gc: cyc, port: 1'b1, err: 1'b0, data: mm[d_addr], msk: bytemask(kn[d_addr])});
                else if (PROT && int'(d_addr) < PL)
                    q.push_back('{gc: cyc, port: 1'b1, err: 1'b1, data: '0, msk: '0});
                else
                    for (int b = 0; b < BW; b++)
                        if (d_be[b]) begin
                            mm[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
                            kn[d_addr][b] = 1'b1;
                        end
            end
            starve = (i_req && !eig) ? ((starve < SM) ? starve + 1 : SM) : 0;
            i_taken = eig;
            d_taken = edg;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_op(input bit port, input logic we, input logic [BW-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd, output int gc);
        int n = 0;
        bit got = 1'b0;
        if (port) begin d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd; end
        else begin i_req = 1'b1; i_addr = a; end
        while (!got && n < 20) begin
            tick();
            n++;
            got = port ? d_taken : i_taken;
        end
        chk("grant_wait", 0, got, 1);
        gc = cyc - 1;
        if (port) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic rd_lit(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] expv);
        int gc;
        req_op(port, 1'b0, '0, a, '0, gc);
        chk("lat1_rvalid", 0, port ? dv[0] : iv[0], 1);
        chk("lat1_rdata", 0, port ? dr[0] : ir[0], expv);
        chk("lat3_early", 1, port ? dv[1] : iv[1], 0);
        tick();
        chk("lat1_single", 0, port ? dv[0] : iv[0], 0);
        chk("lat3_early", 1, port ? dv[1] : iv[1], 0);
        tick();
        chk("lat3_rvalid", 1, port ? dv[1] : iv[1], 1);
        chk("lat3_rdata", 1, port ? dr[1] : ir[1], expv);
    endtask

    function automatic logic [AW-1:0] raddr();
        case ($urandom_range(0, 2))
            0:       return AW'($urandom_range(0, 15));
            1:       return AW'($urandom_range(248, 263));
            default: return AW'($urandom_range(1016, 1023));
        endcase
    endfunction

    initial begin
        int gc, pulses;
        for (int a = 0; a < DEPTH; a++) kn[a] = '0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("por_i_rvalid", 0, iv[0], 0);
        chk("por_d_rdata", 1, dr[1], 0);
        rst = 1'b0;
        tick();

        req_op(1'b1, 1'b1, 4'hF, 10'h100, 32'hDEADBEEF, gc);
        rd_lit(1'b1, 10'h100, 32'hDEADBEEF);

        req_op(1'b1, 1'b1, 4'hF, 10'h200, 32'h11223344, gc);
        req_op(1'b1, 1'b1, 4'h5, 10'h200, 32'hAABBCCDD, gc);
        chk("model_be", 0, mm[10'h200], 32'h11BB33DD);
        rd_lit(1'b1, 10'h200, 32'h11BB33DD);
        rd_lit(1'b0, 10'h200, 32'h11BB33DD);
        req_op(1'b1, 1'b1, 4'h0, 10'h200, 32'hFFFFFFFF, gc);
        rd_lit(1'b1, 10'h200, 32'h11BB33DD);
        req_op(1'b1, 1'b1, 4'hF, 10'h3FF, 32'hCAFEF00D, gc);
        rd_lit(1'b0, 10'h3FF, 32'hCAFEF00D);

        for (int k = 0; k < 8; k++)
            req_op(1'b1, 1'b1, 4'hF, B2B + AW'(k), 32'hA5000000 + k, gc);
        repeat (4) tick();
        for (int t = 0; t <= 10; t++) begin
            i_req = (t < 8);
            i_addr = B2B + AW'(t);
            #1;
            chk("b2b_gnt", 0, ig[0], (t < 8));
            chk("b2b_l1_vld", 0, iv[0], (t >= 1 && t <= 8));
            if (t >= 1 && t <= 8) chk("b2b_l1_data", 0, ir[0], 32'hA5000000 + t - 1);
            chk("b2b_l3_vld", 1, iv[1], (t >= 3));
            if (t >= 3) chk("b2b_l3_data", 1, ir[1], 32'hA5000000 + t - 3);
            tick();
        end
        i_req = 1'b0;
        repeat (3) tick();

        req_op(1'b1, 1'b0, '0, 10'h100, '0, gc);
        rst = 1'b1;
        #1;
        chk("midrst_l1_vld", 0, dv[0], 0);
        chk("midrst_l1_data", 0, dr[0], 0);
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(iv[0]) + int'(iv[1]) + int'(dv[0]) + int'(dv[1]);
        end
        chk("flushed_pulses", 0, pulses, 0);

        i_req = 1'b1; i_addr = 10'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk("arb_d", 0, dg[0], (k % 5 != 4));
            chk("arb_i", 1, ig[1], (k % 5 == 4));
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) tick();

`ifdef MEM_PROTECT_EN
        req_op(1'b1, 1'b1, 4'hF, 10'h0FF, 32'h12345678, gc);
        chk("err_l1", 0, de[0], 1);
        chk("err_l1_no_rvalid", 0, dv[0], 0);
        chk("err_l3_early", 1, de[1], 0);
        tick();
        chk("err_l1_single", 0, de[0], 0);
        tick();
        chk("err_l3", 1, de[1], 1);
        req_op(1'b1, 1'b0, '0, 10'h0FF, '0, gc);
        n_chk++;
        if (dr[0] === 32'h12345678) begin
            n_fail++;
            $display("FAIL prot_blocked dut=L1 cyc=%0d actual=%h required=old contents", cyc, dr[0]);
        end
        req_op(1'b1, 1'b1, 4'hF, 10'h100, 32'h55AA55AA, gc);
        chk("noerr_l1", 0, de[0], 0);
        rd_lit(1'b1, 10'h100, 32'h55AA55AA);
`endif

        for (int t = 0; t < 3000; t++) begin
            if (!i_req || i_taken) begin
                i_req = 1'($urandom_range(0, 1));
                i_addr = raddr();
            end
            if (!d_req || d_taken) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_we = 1'($urandom_range(0, 1));
                d_be = BW'($urandom);
                d_addr = raddr();
                d_wdata = $urandom;
            end
            if (t == 1500) rst = 1'b1;
            if (t == 1503) rst = 1'b0;
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/unified_mem.md
Name: unified_mem

Overview:
- Parametrised single-bank synchronous memory shared by the instruction-fetch path and the load/store path.
- Two independent request ports (fetch port I, data port D) with per-cycle arbitration, byte-enable writes and a configurable read pipeline latency.
- Replaces the fixed 32-bit, mode-selected memory. Sits between the core's fetch/LSU stages and the word-addressed storage array.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width; depth = 2**ADDR_W words.
- LATENCY, 1, read latency in cycles from grant to rvalid; legal range 1..4.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch gets forced priority; legal range 1..15.
- PROT_LIMIT, 256, first writable word address when MEM_PROTECT_EN is defined.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  fetch read data valid pulse
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data-port request
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  byte enables for writes (bit k -> byte k)
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data read data valid pulse
- d_rdata  out  DATA_W  data read data
- d_err  out  1  protection fault pulse (present only with MEM_PROTECT_EN)

Behaviour:
- Reset (async, while rst=1):
  - i_gnt, d_gnt forced 0; i_rvalid, d_rvalid, d_err = 0; i_rdata, d_rdata = 0.
  - Starvation counter = 0; read pipeline flushed, so in-flight reads are dropped and never return.
  - Array contents are not reset.
- Access rate: at most one array access (read or write) per cycle.
- Arbitration (combinational):
  - Only one requester: it is granted.
  - Both requesting: D wins, unless starve_cnt == STARVE_MAX, in which case I wins.
- Starvation counter:
  - Increments when i_req=1 and I loses.
  - Clears when I is granted or i_req=0.
  - Saturates at STARVE_MAX.
- Requesters must hold req/addr/data stable until gnt. A request is consumed in the cycle gnt=1.
- Reads:
  - Array is read at the grant edge.
  - Data travels a LATENCY-deep pipeline tagged with port ID.
  - The matching rvalid pulses for exactly one cycle, LATENCY cycles after the grant cycle (LATENCY=1 -> next cycle).
  - rdata holds its last value while rvalid=0.
  - Back-to-back grants produce back-to-back rvalid pulses, in order.
- Writes:
  - Committed at the grant edge; bytes with d_be[k]=0 are unchanged.
  - d_be = 0 is a granted no-op.
  - Writes produce no rvalid.
- Read-after-write: a read granted in any cycle after a write's grant returns the new data. Same-cycle conflict is impossible (single grant).
- Address range: all 2**ADDR_W addresses are valid; no wrap or aliasing logic.
- Reset mid-operation: pending responses are lost; the first grant after rst deasserts behaves as from power-up.
- Pipeline registers, port tag and starvation counter are the only state besides the array.

Optional Feature:
- MEM_PROTECT_EN. When defined:
  - D-port writes with d_addr < PROT_LIMIT are granted but do not modify the array.
  - d_err pulses for one cycle, LATENCY cycles after that grant.
  - Reads and I-port accesses are unaffected.
- When undefined: the d_err port is absent, and all addresses are writable.

Test Plan:
- Basic read: LATENCY=1. Write 0xDEADBEEF to 0x0100 (d_be=0xF), then D read of 0x0100 -> d_rvalid one cycle after grant, d_rdata=0xDEADBEEF. Repeat with LATENCY=3 -> rvalid exactly 3 cycles after grant.
- Byte enables: write 0x11223344 to 0x0200, then write 0xAABBCCDD with d_be=0x5 -> read returns 0x11BB33DD.
- Arbitration and starvation: i_req and d_req held high continuously, STARVE_MAX=4 -> D granted 4 cycles, I granted on the 5th, pattern repeats. i_rvalid carries the fetch data, D data arrives in order on d_rvalid.
- Back-to-back: I reads 0x0000..0x0007 in consecutive cycles with no D traffic -> 8 consecutive i_rvalid pulses with matching data, no bubbles.
- Reset mid-flight: LATENCY=3, grant a read, assert rst on the next cycle -> no rvalid ever appears for it. All outputs are 0 during rst, starve_cnt = 0 after release.
- MEM_PROTECT_EN, PROT_LIMIT=256:
  - Write 0x12345678 to 0x00FF -> d_err pulses LATENCY cycles after grant, and a later read of 0x00FF returns the old value.
  - Write to 0x0100 -> no d_err, data stored.
